// File: rtl/iccm_port_arbiter_if.sv
// Bus bundle between the fetch adapter, the boot loader and the ICCM SRAM macro.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface iccm_port_arbiter_if #(
  parameter int unsigned Aw = 12,
  parameter int unsigned Dw = 32
);
  localparam int unsigned Mw = Dw / 8;

  // Fetch port (read-only)
  logic          f_req_i;
  logic [Aw-1:0] f_addr_i;
  logic          f_gnt_o;
  logic          f_rvalid_o;
  logic [Dw-1:0] f_rdata_o;

  // Boot-loader port (read/write with byte mask)
  logic          l_req_i;
  logic          l_we_i;
  logic [Aw-1:0] l_addr_i;
  logic [Dw-1:0] l_wdata_i;
  logic [Mw-1:0] l_wmask_i;
  logic          l_gnt_o;
  logic          l_rvalid_o;
  logic [Dw-1:0] l_rdata_o;

  // SRAM macro side
  logic          mem_en_o;
  logic [Mw-1:0] mem_we_o;
  logic [Aw-1:0] mem_addr_o;
  logic [Dw-1:0] mem_wdata_o;
  logic [Dw-1:0] mem_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o,
    input  l_req_i, l_we_i, l_addr_i, l_wdata_i, l_wmask_i,
    output l_gnt_o, l_rvalid_o, l_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output f_req_i, f_addr_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o,
    output l_req_i, l_we_i, l_addr_i, l_wdata_i, l_wmask_i,
    input  l_gnt_o, l_rvalid_o, l_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/iccm_port_arbiter.sv
// Two-port arbiter in front of a single-port instruction SRAM.
// BOOT: only the loader reaches the memory. RUN (after boot_done_i): both ports share it,
// loader wins conflicts. Define ICCM_ARB_RR_EN to arbitrate conflicts round-robin instead.
// Responses come back with a fixed one-cycle latency on the port that owned the access.
module iccm_port_arbiter #(
  parameter int unsigned Aw = 12,
  parameter int unsigned Dw = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                boot_done_i,
  output logic                run_o,
  iccm_port_arbiter_if.slave  bus
);
  localparam int unsigned Mw = Dw / 8;

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e state_q, state_d;
  logic   done_q, done_d;      // boot_done_i seen (it may be only a pulse)
  logic   f_pend_q, f_pend_d;  // fetch owns the response this cycle
  logic   l_pend_q, l_pend_d;  // loader owns the response this cycle
  logic   l_we_q, l_we_d;      // loader's pending access was a write

  logic f_gnt, l_gnt;

`ifdef ICCM_ARB_RR_EN
  logic last_fetch_q, last_fetch_d;  // 1: fetch won the most recent RUN grant
`endif

  // Grant selection; everything is held at zero while reset is asserted
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset) begin
      if (state_q == StBoot) begin
        l_gnt = bus.l_req_i;
      end else if (bus.l_req_i && bus.f_req_i) begin
`ifdef ICCM_ARB_RR_EN
        l_gnt = last_fetch_q;
        f_gnt = ~last_fetch_q;
`else
        l_gnt = 1'b1;
`endif
      end else begin
        l_gnt = bus.l_req_i;
        f_gnt = bus.f_req_i;
      end
    end
  end

  // Next state: leave BOOT only once no loader response is still owed
  always_comb begin
    state_d  = state_q;
    done_d   = done_q | boot_done_i;
    f_pend_d = f_gnt;
    l_pend_d = l_gnt;
    l_we_d   = l_gnt & bus.l_we_i;
    if (state_q == StBoot && (done_q || boot_done_i) && !l_gnt) begin
      state_d = StRun;
    end
  end

`ifdef ICCM_ARB_RR_EN
  // Round-robin pointer follows RUN grants only, so the first RUN conflict goes to the loader
  always_comb begin
    last_fetch_d = last_fetch_q;
    if (state_q == StRun) begin
      if (f_gnt) begin
        last_fetch_d = 1'b1;
      end else if (l_gnt) begin
        last_fetch_d = 1'b0;
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_fetch_q <= 1'b1;
    end else begin
      last_fetch_q <= last_fetch_d;
    end
  end
`endif

  // State and response-ownership registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StBoot;
      done_q   <= 1'b0;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
      l_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      f_pend_q <= f_pend_d;
      l_pend_q <= l_pend_d;
      l_we_q   <= l_we_d;
    end
  end

  // SRAM drive from the winner, and response routing; reset gating drops owed responses
  always_comb begin
    bus.f_gnt_o     = f_gnt;
    bus.l_gnt_o     = l_gnt;
    bus.mem_en_o    = f_gnt | l_gnt;
    bus.mem_addr_o  = f_gnt ? bus.f_addr_i : (l_gnt ? bus.l_addr_i : '0);
    bus.mem_we_o    = (l_gnt && bus.l_we_i) ? bus.l_wmask_i : {Mw{1'b0}};
    bus.mem_wdata_o = l_gnt ? bus.l_wdata_i : '0;
    bus.f_rvalid_o  = reset & f_pend_q;
    bus.f_rdata_o   = (reset && f_pend_q) ? bus.mem_rdata_i : '0;
    bus.l_rvalid_o  = reset & l_pend_q;
    bus.l_rdata_o   = (reset && l_pend_q && !l_we_q) ? bus.mem_rdata_i : '0;
    run_o           = reset & (state_q == StRun);
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares one single-port instruction SRAM (DFFRAM-style macro) between two requesters:
  - a core fetch port (read-only, typically driven by a TL-UL SRAM adapter);
  - a boot-loader port (read/write with byte mask, e.g. a UART programmer).
- Sequences boot: only the loader may access the memory until it signals completion, then both ports share it.
- Sits between the adapters and the memory macro inside the instruction-memory top.

Parameters:
- Aw, 12, SRAM word-address width.
- Dw, 32, SRAM data width; must be a multiple of 8.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- boot_done_i  input  1  loader finished; level or pulse.
- f_req_i  input  1  fetch read request.
- f_addr_i  input  Aw  fetch word address.
- f_gnt_o  output  1  fetch request accepted this cycle.
- f_rvalid_o  output  1  fetch read data valid.
- f_rdata_o  output  Dw  fetch read data.
- l_req_i  input  1  loader request.
- l_we_i  input  1  loader write (1) / read (0).
- l_addr_i  input  Aw  loader word address.
- l_wdata_i  input  Dw  loader write data.
- l_wmask_i  input  Dw/8  loader byte-write mask.
- l_gnt_o  output  1  loader request accepted this cycle.
- l_rvalid_o  output  1  loader response (read data or write ack).
- l_rdata_o  output  Dw  loader read data.
- mem_en_o  output  1  SRAM chip enable.
- mem_we_o  output  Dw/8  SRAM byte write enables.
- mem_addr_o  output  Aw  SRAM address.
- mem_wdata_o  output  Dw  SRAM write data.
- mem_rdata_i  input  Dw  SRAM read data; valid the cycle after an enabled access.
- run_o  output  1  arbiter in RUN state.

Behaviour:
- Reset: synchronous, active-low (reset low at posedge clock).
  - State = BOOT.
  - Pending-response flags cleared.
  - Round-robin pointer (if present) points to fetch.
  - All outputs 0: run_o, gnt/rvalid/rdata on both ports, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o.
- Reset mid-operation: any response owed for the previous cycle's grant is dropped (no rvalid).
- State machine:
  - BOOT: f_gnt_o forced 0; l_req_i granted every cycle.
  - BOOT -> RUN at the posedge where boot_done_i=1 and no loader response is pending.
    - If a response is pending, the transition waits one cycle.
    - A loader request presented in that same cycle is still granted.
  - RUN: terminal until reset; run_o=1 in RUN (registered).
- Grant is combinational, in the same cycle as the request; at most one grant per cycle.
  - RUN, one requester: that requester is granted.
  - RUN, both requesting: loader wins (fixed priority), unless the optional feature is enabled.
- SRAM drive (combinational from the winner):
  - mem_en_o = f_gnt_o | l_gnt_o.
  - mem_addr_o = winner's address; 0 when idle.
  - mem_we_o = l_wmask_i when l_gnt_o & l_we_i; 0 otherwise.
  - mem_wdata_o = l_wdata_i when l_gnt_o, else 0.
- Write with l_wmask_i=0: still granted, memory unchanged, acked normally.
- Response, fixed 1-cycle latency:
  - Registered owner flags f_pend and l_pend, plus a we flag.
  - f_rvalid_o = f_pend; l_rvalid_o = l_pend.
  - f_rdata_o = mem_rdata_i when f_pend, else 0.
  - l_rdata_o = mem_rdata_i when l_pend and the access was a read, else 0 (write ack carries 0).
- Back-to-back: a grant every cycle is allowed, giving full throughput, e.g. alternating owners with responses in matching order.
- Requesters hold req/addr until granted; a request withdrawn before grant is simply ignored.

Optional Feature:
- Macro: ICCM_ARB_RR_EN.
- Defined: round-robin arbitration in RUN.
  - A 1-bit last-winner pointer updates on every grant.
  - When both ports request, the port not granted last wins.
  - Reset value means the loader wins the first conflict after reset.
- Not defined: fixed priority, loader always wins conflicts; no pointer register exists.

Test Plan:
- Reset then BOOT lockout: hold reset=0 for 2 cycles, release; drive f_req_i=1, f_addr_i=0x010 -> f_gnt_o=0, mem_en_o=0, run_o=0 for as long as boot_done_i=0.
- Loader write/readback in BOOT: write 0xDEADBEEF with wmask 0xF to addr 0x004 -> l_gnt_o=1 and mem_we_o=0xF the same cycle, l_rvalid_o=1 with l_rdata_o=0 next cycle. Then write 0x000000AA with wmask 0x1, then read 0x004 -> l_rdata_o=0xDEADBEAA one cycle after grant.
- Boot handoff with pending response: loader read granted in the same cycle boot_done_i=1 -> l_rvalid_o next cycle, run_o=1 one cycle later. Fetch to 0x004 then granted; f_rvalid_o with 0xDEADBEAA follows.
- Conflict, fixed priority (macro off): both ports request in RUN for 3 cycles -> l_gnt_o=1 all 3 cycles, f_gnt_o=0. Fetch is granted in the first cycle l_req_i drops.
- Conflict, round-robin (macro on): both ports request continuously for 4 cycles -> grant sequence loader, fetch, loader, fetch. Each rvalid appears on the matching port one cycle after its grant.
- Reset mid-operation: fetch granted at cycle N, reset=0 at N+1 -> f_rvalid_o=0 at N+1, all outputs 0, state BOOT, run_o=0.
